// File: rtl/fpr_add_arb.sv
// Round-robin arbiter/sequencer sharing one fixed-latency FP add/sub unit between NREQ clients.
// Define FPR_ARB_PRIO0_EN to give requester 0 fixed top priority over the round-robin group.
module fpr_add_arb #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int ADD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [32*NREQ-1:0]   req_a,
    input  logic [32*NREQ-1:0]   req_b,
    input  logic [NREQ-1:0]      req_adsb,
    output logic [31:0]          add_a,
    output logic [31:0]          add_b,
    output logic                 add_adsb,
    input  logic [31:0]          add_res,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [31:0]          rsp_res,
    output logic                 busy
);

    localparam int CW = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          r_state;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  r_tag;
    logic [CW-1:0]   r_cnt;
    logic [31:0]     r_add_a;
    logic [31:0]     r_add_b;
    logic            r_add_adsb;
    logic [31:0]     r_rsp_res;
    logic [IDW-1:0]  r_rsp_id;
    logic            r_rsp_valid;
    logic            r_busy;

    logic            w_win_vld;
    logic [IDW-1:0]  w_win_idx;
    logic [31:0]     w_win_a;
    logic [31:0]     w_win_b;
    logic            w_win_adsb;
    logic [NREQ-1:0] w_grant;

    // Search distance of requester idx from the slot after ptr; smaller wins.
    function automatic int rr_dist(input int idx, input int ptr);
`ifdef FPR_ARB_PRIO0_EN
        if (idx == 0) begin
            return 0;
        end else begin
            return 1 + ((idx - ptr - 1 + 2 * (NREQ - 1)) % (NREQ - 1));
        end
`else
        return (idx - ptr - 1 + 2 * NREQ) % NREQ;
`endif
    endfunction

    // Winner selection and operand mux for the current IDLE cycle.
    always_comb begin
        int best_d;
        best_d     = NREQ;
        w_win_vld  = 1'b0;
        w_win_idx  = '0;
        w_win_a    = 32'h0000_0000;
        w_win_b    = 32'h0000_0000;
        w_win_adsb = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_valid[i] && (rr_dist(i, int'(r_ptr)) < best_d)) begin
                best_d     = rr_dist(i, int'(r_ptr));
                w_win_vld  = 1'b1;
                w_win_idx  = IDW'(i);
                w_win_a    = req_a[32*i +: 32];
                w_win_b    = req_b[32*i +: 32];
                w_win_adsb = req_adsb[i];
            end else begin
                best_d = best_d;
            end
        end
    end

    // One-hot grant, only in IDLE and never while reset is asserted.
    always_comb begin
        w_grant = '0;
        if (rst_n && (r_state == ST_IDLE) && w_win_vld) begin
            for (int i = 0; i < NREQ; i++) begin
                w_grant[i] = (w_win_idx == IDW'(i));
            end
        end else begin
            w_grant = '0;
        end
    end

    // Sequencer: accept, wait out the adder latency, hold the result until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= IDW'(NREQ - 1);
            r_tag       <= '0;
            r_cnt       <= '0;
            r_add_a     <= 32'h0000_0000;
            r_add_b     <= 32'h0000_0000;
            r_add_adsb  <= 1'b0;
            r_rsp_res   <= 32'h0000_0000;
            r_rsp_id    <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_win_vld) begin
                        r_add_a    <= w_win_a;
                        r_add_b    <= w_win_b;
                        r_add_adsb <= w_win_adsb;
                        r_tag      <= w_win_idx;
`ifdef FPR_ARB_PRIO0_EN
                        // Requester 0 sits outside the rotation, so it never moves ptr.
                        if (w_win_idx != '0) begin
                            r_ptr <= w_win_idx;
                        end else begin
                            r_ptr <= r_ptr;
                        end
`else
                        r_ptr      <= w_win_idx;
`endif
                        r_cnt      <= CW'(ADD_LAT - 1);
                        r_busy     <= 1'b1;
                        r_state    <= ST_EXEC;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (r_cnt == '0) begin
                        r_rsp_res   <= add_res;
                        r_rsp_id    <= r_tag;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_state <= ST_RESP;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_grant;
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_adsb  = r_add_adsb;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_res   = r_rsp_res;
    assign busy      = r_busy;

endmodule

// File: tb/tb_fpr_add_arb.sv
// Directed + randomized bench for fpr_add_arb (NREQ=4, ADD_LAT=3) with a stand-in pipelined adder.
module tb_fpr_add_arb;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int LAT  = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [3:0]   req_adsb;
    logic [31:0]  add_a;
    logic [31:0]  add_b;
    logic         add_adsb;
    logic [31:0]  add_res;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_res;
    logic         busy;

    logic [31:0]  ra [4];
    logic [31:0]  rb [4];
    logic         rs [4];
    logic [31:0]  p1;
    logic [31:0]  p2;

    int n_checks = 0;
    int n_err    = 0;
    int mptr     = NREQ - 1;

    fpr_add_arb #(.NREQ(NREQ), .IDW(IDW), .ADD_LAT(LAT)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_adsb(req_adsb),
        .add_a(add_a), .add_b(add_b), .add_adsb(add_adsb), .add_res(add_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_res(rsp_res), .busy(busy)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a    = {ra[3], ra[2], ra[1], ra[0]};
        req_b    = {rb[3], rb[2], rb[1], rb[0]};
        req_adsb = {rs[3], rs[2], rs[1], rs[0]};
    end

    // Stand-in adder: exact results for the known FP cases, a bit-mixing function otherwise.
    function automatic logic [31:0] adder_f(input logic [31:0] a, input logic [31:0] b, input logic s);
        if (a == 32'h4040_0000 && b == 32'h3F80_0000 && s == 1'b0) return 32'h4080_0000;
        if (a == 32'h4000_0000 && b == 32'h3F80_0000 && s == 1'b1) return 32'h3F80_0000;
        return {a[15:0] ^ b[31:16], a[31:16] + b[15:0]} ^ {32{s}};
    endfunction

    // Adder pipeline: result is valid LAT cycles after the operands are registered.
    always_ff @(posedge clk) begin
        p1 <= adder_f(add_a, add_b, add_adsb);
        p2 <= p1;
    end
    assign add_res = p2;

    function automatic int pick(input logic [3:0] v);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(mptr + k) % NREQ]) return (mptr + k) % NREQ;
        end
        return 0;
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete operation starting at the next IDLE cycle; hold = RESP cycles with rsp_ready low.
    task automatic op(input logic [3:0] vm, input int hold, input bit wd, output logic [3:0] gnt);
        logic [31:0] e;
        int win;
        cyc();
        req_valid = vm;
        rsp_ready = (hold == 0);
        #1;
        gnt = req_ready;
        win = pick(vm);
        chk("grant", 32'(req_ready), 32'(4'b0001 << win));
        chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        e = adder_f(ra[win], rb[win], rs[win]);
        mptr = win;
        for (int c = 1; c <= LAT + 1; c++) begin
            cyc();
            if (wd && c == 1) req_valid[3] = 1'b1;
            else if (wd && c == LAT + 1) req_valid = vm;
            #1;
            if (c <= LAT) begin
                chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
                chk("exec_busy", 32'(busy), 32'd1);
                chk("exec_add_a", add_a, ra[win]);
                chk("exec_add_b", add_b, rb[win]);
                chk("exec_add_adsb", 32'(add_adsb), 32'(rs[win]));
            end else begin
                chk("rsp_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_res", rsp_res, e);
                chk("rsp_id", 32'(rsp_id), 32'(win));
            end
            chk("busy_ready", 32'(req_ready), 32'd0);
        end
        for (int h = 1; h < hold; h++) begin
            cyc();
            #1;
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_res", rsp_res, e);
            chk("hold_id", 32'(rsp_id), 32'(win));
            chk("hold_ready", 32'(req_ready), 32'd0);
        end
        if (hold > 0) begin
            cyc();
            rsp_ready = 1'b1;
            #1;
            chk("release_valid", 32'(rsp_valid), 32'd1);
            chk("release_res", rsp_res, e);
            chk("release_ready", 32'(req_ready), 32'd0);
        end
    endtask

    initial begin
        logic [3:0] g;
        logic [3:0] vm;
        int fair_exp [5];
        fair_exp = '{0, 1, 2, 3, 0};
        rst_n     = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ra[i] = 32'h3F80_0000 + 32'(i);
            rb[i] = 32'h4000_0000 + 32'(i << 4);
            rs[i] = 1'(i);
        end

        // Reset values, with all requests pending.
        repeat (2) cyc();
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_add_b", add_b, 32'd0);
        chk("rst_add_adsb", 32'(add_adsb), 32'd0);
        chk("rst_rsp_res", rsp_res, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        cyc();
        rst_n     = 1'b1;
        req_valid = 4'h0;

        // Fairness: all requesters valid, rsp_ready high.
        for (int k = 0; k < 5; k++) begin
            op(4'hF, 0, 1'b0, g);
            chk("fair_order", 32'(g), 32'(4'b0001 << fair_exp[k]));
        end

        // Single add from requester 2.
        ra[2] = 32'h4040_0000; rb[2] = 32'h3F80_0000; rs[2] = 1'b0;
        op(4'b0100, 0, 1'b0, g);
        chk("add_grant", 32'(g), 32'h4);

        // Subtract from requester 0.
        ra[0] = 32'h4000_0000; rb[0] = 32'h3F80_0000; rs[0] = 1'b1;
        op(4'b0001, 0, 1'b0, g);

        // Backpressure while requester 1 is valid.
        op(4'b0010, 5, 1'b0, g);

        // Requester 3 shows up during EXEC and leaves before IDLE.
        op(4'b0100, 2, 1'b1, g);
        op(4'b0001, 0, 1'b0, g);
        chk("withdrawn_not_granted", 32'(g), 32'h1);

        // Reset during the second EXEC cycle.
        cyc();
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        #1;
        chk("pre_rst_grant", 32'(req_ready), 32'(4'b0001 << pick(4'b0100)));
        cyc();
        cyc();
        rst_n     = 1'b0;
        req_valid = 4'hF;
        #1;
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_add_a", add_a, 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        cyc();
        rst_n     = 1'b1;
        req_valid = 4'h0;
        mptr      = NREQ - 1;
        for (int k = 0; k < 6; k++) begin
            cyc();
            #1;
            chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        op(4'hF, 0, 1'b0, g);
        chk("post_rst_first_grant", 32'(g), 32'h1);

        // Randomized operations against the reference model.
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 4; i++) begin
                ra[i] = $urandom;
                rb[i] = $urandom;
                rs[i] = 1'($urandom);
            end
            vm = 4'($urandom_range(1, 15));
            op(vm, $urandom_range(0, 3), (!vm[3]) && ($urandom_range(0, 1) == 1), g);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/fpr_add_arb.md
# fpr_add_arb

Round-robin arbiter and sequencer that shares one single-precision add/subtract datapath (the `fpr_add` unit, optionally wrapped with pipeline registers) between `NREQ` requesters. It accepts one operation at a time over per-requester valid/ready handshakes and drives registered operands into the shared adder. After a fixed `ADD_LAT` cycles it captures the adder result and returns it with the requester's index over a single valid/ready response channel. It sits between the issue logic of the FP clients and the shared adder instance.

## Interface
- `NREQ`, 4: number of requesters, 2..16.
- `IDW`, 2: width of `rsp_id`; must satisfy 2^IDW >= NREQ.
- `ADD_LAT`, 1: adder latency in cycles from registered operands to a valid `add_res`; must be >= 1.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NREQ  per-requester operation request.
- `req_ready`  out  NREQ  one-hot grant; the handshake completes when `req_valid[i] & req_ready[i]`.
- `req_a`  in  32*NREQ  operand A of requester i in bits [32i+31:32i].
- `req_b`  in  32*NREQ  operand B of requester i, same packing.
- `req_adsb`  in  NREQ  0 = add, 1 = subtract, per requester.
- `add_a`, `add_b`  out  32  registered operands to the shared adder.
- `add_adsb`  out  1  registered add/sub select to the shared adder.
- `add_res`  in  32  shared adder result (`Res`).
- `rsp_valid`  out  1  a result is held.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  IDW  index of the requester that owns `rsp_res`.
- `rsp_res`  out  32  captured result.
- `busy`  out  1  high in EXEC or RESP.

## Operation
- The FSM has three states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: if any `req_valid` is high, pick a winner by round-robin, searching upward from `ptr+1` modulo NREQ. `req_ready` is high only for the winner, combinationally in that cycle. On that edge:
  - latch the winner's `req_a`/`req_b`/`req_adsb` into `add_a`/`add_b`/`add_adsb`;
  - store the winner's index as the tag;
  - set `ptr` to the winner;
  - load the latency counter with ADD_LAT-1;
  - go to EXEC.
- EXEC: `req_ready` is all zero. The counter decrements each cycle. In the cycle where the counter equals 0, capture `add_res` into `rsp_res` and the tag into `rsp_id`, and go to RESP. `add_*` hold their values throughout EXEC.
- RESP: `rsp_valid` = 1, and `rsp_res`/`rsp_id` are stable. On `rsp_ready` = 1, go to IDLE. No new request is accepted in the same cycle.
- The arbiter performs no arithmetic on the operands. Sign, exponent and mantissa behaviour belong to the adder; operands pass through bit-exact.
- A requester may drop `req_valid` without a handshake. Requests not granted are ignored until the next IDLE cycle.
- `ptr` updates only on a completed request handshake.

## Timing
- Reset values (asynchronous, while `rst_n` = 0):
  - state IDLE;
  - `ptr` = NREQ-1, so requester 0 wins first;
  - `add_a`, `add_b`, `add_adsb`, `rsp_res`, `rsp_id` = 0;
  - `rsp_valid`, `busy` = 0;
  - `req_ready` forced to 0.
- Latency: a request handshake in cycle t gives `rsp_valid` = 1 first in cycle t+ADD_LAT+1.
- Throughput: at most one operation per ADD_LAT+2 cycles, when `rsp_ready` is held high.
- `rsp_valid` stays high, with stable data, until the `rsp_ready` handshake.
- Reset asserted mid-EXEC or mid-RESP aborts the operation. The result is discarded and no response is issued after reset.
- Simultaneous requests: exactly one grant per IDLE cycle, and never two bits of `req_ready` set.
- Pointer wrap: after the grant at index NREQ-1, the search starts at index 0.

## Configuration
- `FPR_ARB_PRIO0_EN` defined:
  - requester 0 has fixed highest priority and wins whenever `req_valid[0]` = 1 in IDLE;
  - requesters 1..NREQ-1 share round-robin among themselves, and `ptr` only tracks those grants.
- Not defined: pure round-robin over all NREQ requesters, as described above.

## Test plan
- Single add, NREQ=4, ADD_LAT=1:
  - stimulus: requester 2 sends a=0x40400000, b=0x3F800000, adsb=0;
  - required: `req_ready` = 4'b0100 in the request cycle; `rsp_valid` exactly 2 cycles later with `rsp_res` = 0x40800000 and `rsp_id` = 2.
- Subtract, ADD_LAT=3:
  - stimulus: requester 0 sends a=0x40000000, b=0x3F800000, adsb=1;
  - required: `rsp_res` = 0x3F800000 and `rsp_id` = 0, with `rsp_valid` rising 4 cycles after the handshake.
- Fairness:
  - stimulus: all four `req_valid` held high and `rsp_ready` = 1 from reset;
  - required: grant order 0,1,2,3,0; with `FPR_ARB_PRIO0_EN` the order is 0,0,0,… .
- Backpressure:
  - stimulus: `rsp_ready` = 0 for 5 cycles in RESP while requester 1 is valid;
  - required: `rsp_valid`, `rsp_res` and `rsp_id` stay stable; no `req_ready` until the cycle after `rsp_ready` = 1.
- Reset mid-EXEC (ADD_LAT=3):
  - stimulus: pulse `rst_n` low during the second EXEC cycle;
  - required: all outputs go to their reset values immediately; no `rsp_valid` afterwards; the next grant goes to requester 0.
- Withdrawn request:
  - stimulus: requester 3 raises `req_valid` during EXEC and drops it before IDLE;
  - required: requester 3 is never granted and no response carries `rsp_id` = 3.
